// File: rtl/sdram_port_arbiter_if.sv
// Requester and SDRAM master-port signals shared between the arbiter and its neighbours.
// The master modport is the arbiter's view; slave is the requesters/SDRAM side.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 32
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    logic              wr_done;
    logic              sdram_read_en;
    logic              sdram_write_en;
    logic [ADDR_W-1:0] sdram_address;
    logic [DATA_W-1:0] sdram_writedata;
    logic              sdram_waitrequest;
    logic              sdram_datareadvalid;
    logic [DATA_W-1:0] sdram_data;

    modport master (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  sdram_waitrequest, sdram_datareadvalid, sdram_data,
        output rd_gnt, rd_data, rd_valid, wr_gnt, wr_done,
        output sdram_read_en, sdram_write_en, sdram_address, sdram_writedata
    );

    modport slave (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output sdram_waitrequest, sdram_datareadvalid, sdram_data,
        input  rd_gnt, rd_data, rd_valid, wr_gnt, wr_done,
        input  sdram_read_en, sdram_write_en, sdram_address, sdram_writedata
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM master port between the pixel-fetch reader
// and the result-writeback writer; one access outstanding, read timeout flagged.
module sdram_port_arbiter #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 32,
    parameter int RD_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    sdram_port_arbiter_if.master bus,
    output logic                busy,
    output logic                timeout_err
);
    localparam int CNT_W = $clog2(RD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD} state_t;
    typedef enum logic {SERVED_RD = 1'b0, SERVED_WR = 1'b1} served_t;

    state_t            state, state_nxt;
    served_t           last_served;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              take_rd, take_wr, rd_hit, rd_timeout, wr_accept;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        take_rd    = 1'b0;
        take_wr    = 1'b0;
        rd_hit     = 1'b0;
        rd_timeout = 1'b0;
        wr_accept  = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester not served last time wins
                if (bus.rd_req && (!bus.wr_req || last_served == SERVED_WR)) begin
                    take_rd   = 1'b1;
                    state_nxt = RD_CMD;
                end else if (bus.wr_req) begin
                    take_wr   = 1'b1;
                    state_nxt = WR_CMD;
                end
            end
            RD_CMD: if (!bus.sdram_waitrequest) state_nxt = RD_WAIT;
            RD_WAIT: begin
                rd_hit     = bus.sdram_datareadvalid;
                rd_timeout = !bus.sdram_datareadvalid && (wait_cnt == CNT_MAX);
                if (rd_hit || rd_timeout) state_nxt = IDLE;
            end
            WR_CMD: begin
                wr_accept = !bus.sdram_waitrequest;
                if (wr_accept) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus.rd_gnt   <= 1'b0;
            bus.wr_gnt   <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.wr_done  <= 1'b0;
            bus.rd_data  <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wait_cnt     <= '0;
            last_served  <= SERVED_WR;
            timeout_err  <= 1'b0;
        end else begin
            bus.rd_gnt   <= take_rd;
            bus.wr_gnt   <= take_wr;
            bus.rd_valid <= rd_hit || rd_timeout;
            bus.wr_done  <= wr_accept;
            if (rd_hit)          bus.rd_data <= bus.sdram_data;
            else if (rd_timeout) bus.rd_data <= '0;
            if (state == RD_CMD)       wait_cnt <= '0;
            else if (state == RD_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
            if (clear) last_served <= SERVED_WR;
            if (take_rd) begin
                addr_q      <= bus.rd_addr;
                last_served <= SERVED_RD;
            end else if (take_wr) begin
                addr_q      <= bus.wr_addr;
                wdata_q     <= bus.wr_data;
                last_served <= SERVED_WR;
            end
            // A timeout in the same cycle as clear still sets the flag
            if (rd_timeout) timeout_err <= 1'b1;
            else if (clear) timeout_err <= 1'b0;
        end
    end

    assign bus.sdram_read_en   = (state == RD_CMD);
    assign bus.sdram_write_en  = (state == WR_CMD);
    assign bus.sdram_address   = addr_q;
    assign bus.sdram_writedata = wdata_q;
    assign busy                = (state != IDLE);
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with hand-computed cycle-by-cycle expectations.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
    logic clk;
    logic n_rst;
    logic clear;
    logic busy;
    logic timeout_err;
    int   total = 0;
    int   bad   = 0;

    sdram_port_arbiter_if #(.ADDR_W(26), .DATA_W(32)) bus ();

    sdram_port_arbiter #(.ADDR_W(26), .DATA_W(32), .RD_TIMEOUT(8)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (clear),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the rising edge
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_rst = 1'b0;
        clear = 1'b0;
        bus.rd_req = 1'b0;
        bus.rd_addr = '0;
        bus.wr_req = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.sdram_waitrequest = 1'b0;
        bus.sdram_datareadvalid = 1'b0;
        bus.sdram_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_rd_gnt", bus.rd_gnt, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_read_en", bus.sdram_read_en, 0);
        check("rst_write_en", bus.sdram_write_en, 0);
        check("rst_address", bus.sdram_address, 0);
        check("rst_timeout", timeout_err, 0);
        n_rst = 1'b1;

        // Single read, data returned in the first RD_WAIT cycle
        bus.rd_req = 1'b1;
        bus.rd_addr = 26'h0000100;
        step;
        check("rd1_gnt", bus.rd_gnt, 1);
        check("rd1_read_en", bus.sdram_read_en, 1);
        check("rd1_addr", bus.sdram_address, 26'h0000100);
        check("rd1_write_en", bus.sdram_write_en, 0);
        bus.rd_req = 1'b0;
        bus.rd_addr = 26'h3FFFFFF;
        step;
        check("rd1_wait_read_en", bus.sdram_read_en, 0);
        check("rd1_wait_gnt", bus.rd_gnt, 0);
        check("rd1_wait_busy", busy, 1);
        check("rd1_addr_hold", bus.sdram_address, 26'h0000100);
        bus.sdram_datareadvalid = 1'b1;
        bus.sdram_data = 32'hDEADBEEF;
        step;
        check("rd1_valid", bus.rd_valid, 1);
        check("rd1_data", bus.rd_data, 32'hDEADBEEF);
        check("rd1_idle", busy, 0);
        bus.sdram_datareadvalid = 1'b0;
        bus.sdram_data = '0;
        step;
        check("rd1_valid_pulse", bus.rd_valid, 0);

        // Write held off by waitrequest for three cycles
        bus.wr_req = 1'b1;
        bus.wr_addr = 26'h2000000;
        bus.wr_data = 32'h12345678;
        bus.sdram_waitrequest = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step;
            check("wr_write_en", bus.sdram_write_en, 1);
            check("wr_gnt", bus.wr_gnt, (i == 1) ? 1 : 0);
            check("wr_addr", bus.sdram_address, 26'h2000000);
            check("wr_wdata", bus.sdram_writedata, 32'h12345678);
            check("wr_done_early", bus.wr_done, 0);
            check("wr_read_en", bus.sdram_read_en, 0);
            if (i == 1) begin
                bus.wr_req = 1'b0;
                bus.wr_addr = '0;
                bus.wr_data = '0;
            end
            if (i == 4) bus.sdram_waitrequest = 1'b0;
        end
        step;
        check("wr_done", bus.wr_done, 1);
        check("wr_write_en_off", bus.sdram_write_en, 0);
        check("wr_idle", busy, 0);
        check("wr_wdata_hold", bus.sdram_writedata, 32'h12345678);
        step;
        check("wr_done_pulse", bus.wr_done, 0);

        // Contention: both requests held, read served first after a write
        bus.rd_req = 1'b1;
        bus.rd_addr = 26'h0000040;
        bus.wr_req = 1'b1;
        bus.wr_addr = 26'h0000080;
        bus.wr_data = 32'h55AA55AA;
        bus.sdram_datareadvalid = 1'b1;
        bus.sdram_data = 32'hCAFEF00D;
        for (int c = 1; c <= 9; c++) begin
            step;
            check("rr_rd_gnt", bus.rd_gnt, (c == 1 || c == 6) ? 1 : 0);
            check("rr_wr_gnt", bus.wr_gnt, (c == 4 || c == 9) ? 1 : 0);
            check("rr_rd_valid", bus.rd_valid, (c == 3 || c == 8) ? 1 : 0);
            check("rr_wr_done", bus.wr_done, (c == 5) ? 1 : 0);
            check("rr_exclusive", bus.sdram_read_en & bus.sdram_write_en, 0);
            if (c == 9) begin
                bus.rd_req = 1'b0;
                bus.wr_req = 1'b0;
                bus.sdram_datareadvalid = 1'b0;
            end
        end
        check("rr_rd_data", bus.rd_data, 32'hCAFEF00D);
        step;
        check("rr_last_wr_done", bus.wr_done, 1);
        step;

        // Data arriving in the last RD_WAIT cycle beats the timeout
        bus.rd_req = 1'b1;
        bus.rd_addr = 26'h0ABCDEF;
        step;
        check("vw_gnt", bus.rd_gnt, 1);
        bus.rd_req = 1'b0;
        for (int c = 2; c <= 9; c++) begin
            step;
            check("vw_busy", busy, 1);
            check("vw_no_valid", bus.rd_valid, 0);
            if (c == 9) begin
                bus.sdram_datareadvalid = 1'b1;
                bus.sdram_data = 32'h0BADF00D;
            end
        end
        step;
        check("vw_valid", bus.rd_valid, 1);
        check("vw_data", bus.rd_data, 32'h0BADF00D);
        check("vw_no_err", timeout_err, 0);
        bus.sdram_datareadvalid = 1'b0;
        step;

        // Timeout with clear asserted on the same edge; set wins
        bus.rd_req = 1'b1;
        bus.rd_addr = 26'h0000055;
        step;
        check("to_gnt", bus.rd_gnt, 1);
        bus.rd_req = 1'b0;
        for (int c = 2; c <= 9; c++) begin
            step;
            check("to_busy", busy, 1);
            check("to_no_valid", bus.rd_valid, 0);
            check("to_no_err_yet", timeout_err, 0);
            if (c == 9) clear = 1'b1;
        end
        step;
        clear = 1'b0;
        check("to_valid", bus.rd_valid, 1);
        check("to_data_zero", bus.rd_data, 0);
        check("to_err", timeout_err, 1);
        check("to_idle", busy, 0);
        step;
        check("to_valid_pulse", bus.rd_valid, 0);
        check("to_err_sticky", timeout_err, 1);
        clear = 1'b1;
        step;
        clear = 1'b0;
        check("to_err_cleared", timeout_err, 0);

        // Tie after clear goes to the read; then reset mid-read
        bus.rd_req = 1'b1;
        bus.rd_addr = 26'h0000123;
        bus.wr_req = 1'b1;
        bus.wr_addr = 26'h0000321;
        step;
        check("clr_tie_rd_gnt", bus.rd_gnt, 1);
        check("clr_tie_wr_gnt", bus.wr_gnt, 0);
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        step;
        check("mr_in_wait", busy, 1);
        #2;
        n_rst = 1'b0;
        #1;
        check("mr_busy", busy, 0);
        check("mr_read_en", bus.sdram_read_en, 0);
        check("mr_address", bus.sdram_address, 0);
        check("mr_rd_data", bus.rd_data, 0);
        bus.sdram_datareadvalid = 1'b1;
        bus.sdram_data = 32'h77777777;
        step;
        check("mr_no_valid", bus.rd_valid, 0);
        n_rst = 1'b1;
        step;
        step;
        check("mr_stray_valid", bus.rd_valid, 0);
        check("mr_stray_data", bus.rd_data, 0);
        check("mr_stray_busy", busy, 0);
        bus.sdram_datareadvalid = 1'b0;
        bus.rd_req = 1'b1;
        bus.rd_addr = 26'h2AAAAAA;
        step;
        check("mr_new_gnt", bus.rd_gnt, 1);
        check("mr_new_addr", bus.sdram_address, 26'h2AAAAAA);
        bus.rd_req = 1'b0;
        step;
        bus.sdram_datareadvalid = 1'b1;
        bus.sdram_data = 32'h13579BDF;
        step;
        check("mr_new_valid", bus.rd_valid, 1);
        check("mr_new_data", bus.rd_data, 32'h13579BDF);
        bus.sdram_datareadvalid = 1'b0;
        step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
